// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: operation encoding,
// FSM states and small decode helpers.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation; used both to take operand magnitudes
// and to restore the sign of products, quotients and remainders.
module muldiv_signfix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] res_o
);

  assign res_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Sequential multiply/divide unit: one shift-add or restoring shift-subtract
// step per cycle on operand magnitudes, sign-corrected on completion.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             divby0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   upper_q, upper_d;   // partial product high half / remainder
  logic [WIDTH-1:0]   lower_q, lower_d;   // multiplier / dividend-quotient
  logic [WIDTH-1:0]   m_q, m_d;           // multiplicand / divisor magnitude
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               divby0_q, divby0_d;
  logic               busy_q, busy_d;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   step_upper, step_lower;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed, rem_fixed;

  // In LOAD the raw operands sit in lower_q / m_q.
  assign sign_a = op_is_signed(op_q) & lower_q[WIDTH-1];
  assign sign_b = op_is_signed(op_q) & m_q[WIDTH-1];

  muldiv_signfix #(.WIDTH(WIDTH)) u_fix_a (
    .val_i(lower_q), .neg_i(sign_a), .res_o(a_mag)
  );
  muldiv_signfix #(.WIDTH(WIDTH)) u_fix_b (
    .val_i(m_q), .neg_i(sign_b), .res_o(b_mag)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    step_upper = upper_q;
    step_lower = lower_q;
    mul_sum    = '0;
    div_sh     = '0;
    div_diff   = '0;
    if (op_is_div(op_q)) begin
      // upper_q < divisor always holds, so bit WIDTH of the difference is its sign.
      div_sh   = {upper_q, lower_q[WIDTH-1]};
      div_diff = div_sh - {1'b0, m_q};
      if (!div_diff[WIDTH]) begin
        step_upper = div_diff[WIDTH-1:0];
        step_lower = {lower_q[WIDTH-2:0], 1'b1};
      end else begin
        step_upper = div_sh[WIDTH-1:0];
        step_lower = {lower_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      mul_sum    = {1'b0, upper_q} + {1'b0, (lower_q[0] ? m_q : {WIDTH{1'b0}})};
      step_upper = mul_sum[WIDTH:1];
      step_lower = {mul_sum[0], lower_q[WIDTH-1:1]};
    end
  end

  // Results are corrected from the final step so hi/lo are valid alongside done.
  muldiv_signfix #(.WIDTH(2 * WIDTH)) u_fix_prod (
    .val_i({step_upper, step_lower}), .neg_i(neg_q), .res_o(prod_fixed)
  );
  muldiv_signfix #(.WIDTH(WIDTH)) u_fix_quo (
    .val_i(step_lower), .neg_i(neg_q), .res_o(quo_fixed)
  );
  muldiv_signfix #(.WIDTH(WIDTH)) u_fix_rem (
    .val_i(step_upper), .neg_i(neg_rem_q), .res_o(rem_fixed)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    upper_d   = upper_q;
    lower_d   = lower_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divby0_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op_e'(op);
          lower_d = a;
          m_d     = b;
          upper_d = '0;
          cnt_d   = '0;
          if (op_is_div(op_e'(op)) && (b == '0)) begin
            state_d  = DONE;
            done_d   = 1'b1;
            divby0_d = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          lower_d   = a_mag;
          m_d       = b_mag;
          upper_d   = '0;
          cnt_d     = '0;
          neg_d     = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          upper_d = step_upper;
          lower_d = step_lower;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
            if (op_is_div(op_q)) begin
              hi_d = rem_fixed;
              lo_d = quo_fixed;
            end else begin
              hi_d = prod_fixed[2*WIDTH-1:WIDTH];
              lo_d = prod_fixed[WIDTH-1:0];
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= MULT;
      upper_q   <= '0;
      lower_q   <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divby0_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      upper_q   <= upper_d;
      lower_q   <= lower_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divby0_q  <= divby0_d;
      busy_q    <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign divby0 = divby0_q;
  assign hi     = hi_q;
  assign lo     = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit at WIDTH=32: results, latency,
// divide-by-zero, abort and mid-operation reset behaviour.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset, start, abort;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, divby0;
  logic [W-1:0] hi, lo;

  typedef struct {
    string        tag;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .abort (abort),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .divby0(divby0),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_op(input string tag, input op_e o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input logic exp_dz,
                        input int exp_lat, input logic with_abort = 1'b0);
    exp_t e;
    exp_t got;
    int   n;
    bit   seen;
    e.tag = tag; e.hi = exp_hi; e.lo = exp_lo; e.dz = exp_dz; e.lat = exp_lat;
    sb_q.push_back(e);
    op = o; a = av; b = bv; start = 1'b1; abort = with_abort;
    tick();
    start = 1'b0; abort = 1'b0;
    check({tag, " busy_c1"}, 64'(busy), 64'(1));
    n = 1;
    seen = 0;
    while (n <= W + 10 && !seen) begin
      if (done) begin
        seen = 1;
        got = sb_q.pop_front();
        check({got.tag, " latency"}, 64'(n), 64'(got.lat));
        check({got.tag, " hi"}, 64'(hi), 64'(got.hi));
        check({got.tag, " lo"}, 64'(lo), 64'(got.lo));
        check({got.tag, " divby0"}, 64'(divby0), 64'(got.dz));
      end else begin
        tick();
        n++;
      end
    end
    if (!seen) begin
      check({tag, " done_timeout"}, 64'(done), 64'(1));
      void'(sb_q.pop_front());
    end
    tick();
    check({tag, " done_pulse"}, 64'(done), 64'(0));
    check({tag, " idle_after"}, 64'(busy), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;

    reset = 1'b1; start = 1'b0; abort = 1'b0; op = 2'b00; a = '0; b = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset divby0", 64'(divby0), 64'(0));
    check("reset hi", 64'(hi), 64'(0));
    check("reset lo", 64'(lo), 64'(0));

    run_op("mult_neg3x7", MULT, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34);
    run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34);
    run_op("mult_minxmin", MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 34);
    run_op("mult_start_abort", MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 34, 1'b1);
    run_op("div_neg7by2", DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
    run_op("div_min_by_m1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34);
    run_op("div_7by_m2", DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 34);
    run_op("divu_47by7", DIVU, 32'd47, 32'd7, 32'd5, 32'd6, 1'b0, 34);
    run_op("divu_by0", DIVU, 32'd100, 32'd0, 32'd5, 32'd6, 1'b1, 1);

    // Abort mid-run with a re-pulsed start that must not be queued.
    dones = 0;
    op = MULTU; a = 32'd3; b = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (done) dones++;
      start = (c == 5);
      a = (c == 5) ? 32'd9 : 32'd3;
      abort = (c == 10);
      tick();
    end
    start = 1'b0; abort = 1'b0;
    check("abort busy_c11", 64'(busy), 64'(0));
    check("abort done_c11", 64'(done), 64'(0));
    check("abort hi_hold", 64'(hi), 64'(5));
    check("abort lo_hold", 64'(lo), 64'(6));
    for (int c = 0; c < 40; c++) begin
      if (done) dones++;
      tick();
    end
    check("abort no_done", 64'(dones), 64'(0));
    run_op("multu_3x4", MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 34);

    // Reset in cycle 20 of a running divide.
    dones = 0;
    op = DIVU; a = 32'd1000; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 20; c++) begin
      if (done) dones++;
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid busy", 64'(busy), 64'(0));
    check("rst_mid done", 64'(done), 64'(0));
    check("rst_mid divby0", 64'(divby0), 64'(0));
    check("rst_mid hi", 64'(hi), 64'(0));
    check("rst_mid lo", 64'(lo), 64'(0));
    for (int c = 0; c < 40; c++) begin
      if (done) dones++;
      tick();
    end
    check("rst_mid no_done", 64'(dones), 64'(0));
    run_op("divu_1000by7", DIVU, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0, 34);

    check("scoreboard empty", 64'(sb_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; legal values 4..64.
REQ-002 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request an operation; sampled only in IDLE.
REQ-005 Port: op  input  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 Port: abort  input  1  cancel the operation in progress.
REQ-007 Port: a  input  WIDTH  multiplicand or dividend; sampled with start.
REQ-008 Port: b  input  WIDTH  multiplier or divisor; sampled with start.
REQ-009 Port: busy  output  1  high in every state except IDLE.
REQ-010 Port: done  output  1  one-cycle completion pulse.
REQ-011 Port: divby0  output  1  one-cycle pulse; DIV or DIVU with b == 0.
REQ-012 Port: hi  output  WIDTH  product upper half, or remainder.
REQ-013 Port: lo  output  WIDTH  product lower half, or quotient.

Function
REQ-014 The FSM SHALL have four states: IDLE, LOAD, RUN, DONE.
REQ-015 IDLE with start=1 SHALL capture op, a and b, then go to LOAD, except a divide with b==0, which SHALL go to DONE.
REQ-016 LOAD SHALL form operand magnitudes and the result signs: signed ops use absolute values, unsigned ops pass operands unchanged; it then goes to RUN.
REQ-017 RUN SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per cycle for exactly WIDTH cycles, counted by a $clog2(WIDTH+1)-bit counter, then go to DONE.
REQ-018 DONE SHALL load hi and lo, drive done=1 and return to IDLE on the next edge.
REQ-019 Latency: done SHALL be high in cycle WIDTH+2 after the start-accepting edge; divide-by-zero done SHALL be high in cycle 1.
REQ-020 Multiply results SHALL be the exact 2*WIDTH-bit product: {hi,lo}.
REQ-021 Divide results SHALL be truncated toward zero, with quotient in lo and remainder in hi; the remainder sign SHALL equal the dividend sign.
REQ-022 Signed DIV of most-negative by -1 SHALL return lo=most-negative and hi=0, with no flag.
REQ-023 Divide-by-zero SHALL assert divby0 and done in the same cycle and leave hi and lo unchanged.
REQ-024 hi and lo SHALL hold their value between completions and change only in DONE.
REQ-025 start while busy SHALL be ignored; no queuing.
REQ-026 abort in LOAD or RUN SHALL return the FSM to IDLE on the next edge, with no done and hi/lo unchanged.
REQ-027 abort in DONE or IDLE SHALL have no effect.
REQ-028 If start and abort are both high in IDLE, start SHALL win.
REQ-029 done and divby0 SHALL be registered outputs, not combinational from inputs.

Reset
REQ-030 reset SHALL force state IDLE, busy=0, done=0, divby0=0, hi=0, lo=0, and clear the counter and datapath registers.
REQ-031 reset SHALL take priority over start and abort, including mid-operation; no done SHALL follow.

Structure
REQ-032 Package muldiv_pkg SHALL hold the op encoding enum (MULT, MULTU, DIV, DIVU) and the FSM state enum.
REQ-033 WIDTH SHALL remain a module parameter, not a package constant.
REQ-034 One sub-module, muldiv_signfix, SHALL provide conditional two's-complement negation of a WIDTH-bit value; it is used for operand magnitudes and for result sign correction.

Verification (WIDTH=32)
REQ-035 MULT a=FFFFFFFD b=00000007 -> done in cycle 34, hi=FFFFFFFF, lo=FFFFFFEB.
REQ-036 MULTU a=FFFFFFFF b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
REQ-037 DIV a=FFFFFFF9 b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; then DIV a=80000000 b=FFFFFFFF -> lo=80000000, hi=00000000.
REQ-038 DIVU a=100 b=0 with prior hi/lo=5/6 -> done=divby0=1 in cycle 1, hi=5, lo=6 retained.
REQ-039 MULTU 3*4 with start re-pulsed at cycle 5 and abort at cycle 10 -> no done, hi/lo unchanged, busy=0 from cycle 11; a subsequent MULTU 3*4 -> lo=12.
REQ-040 reset at cycle 20 of DIVU 1000/7 -> all outputs 0 next cycle, no done; a rerun -> lo=142, hi=6.
